luces_secuenciador: RTL

Parametrised LED pattern sequencer driving the board's green LED bank (LEDG). It generalises the fixed 8-LED light FSM in three ways:
- LED count is set by a parameter.
- Step rate comes from a programmable prescaler.
- Four runtime-selectable patterns are available: rotate left, rotate right, ping-pong and fill/drain.

It sits directly behind the board-level top, with ENABLE from a switch or key and LEDG to the pins.

---
 rtl/luces_pkg.sv | 34 +++
 rtl/divisor_tick.sv | 34 +++
 rtl/luces_secuenciador.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/luces_pkg.sv
// Shared encodings for the LED pattern sequencer: pattern select values,
// FSM states and the mapping from a pattern to its first run state.
package luces_pkg;

  typedef enum logic [1:0] {
    MODO_ROT_L    = 2'd0,
    MODO_ROT_R    = 2'd1,
    MODO_PINGPONG = 2'd2,
    MODO_LLENADO  = 2'd3
  } modo_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ROT_L   = 3'd1,
    ST_ROT_R   = 3'd2,
    ST_PP_UP   = 3'd3,
    ST_PP_DOWN = 3'd4,
    ST_FILL    = 3'd5,
    ST_DRAIN   = 3'd6
  } estado_t;

  function automatic estado_t primer_estado(input logic [1:0] modo);
    estado_t e;
    case (modo)
      MODO_ROT_L:    e = ST_ROT_L;
      MODO_ROT_R:    e = ST_ROT_R;
      MODO_PINGPONG: e = ST_PP_UP;
      MODO_LLENADO:  e = ST_FILL;
      default:       e = ST_IDLE;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Step-rate prescaler: counts 0..DIV while enabled and ticks on the terminal
// count. A DIV that drops below the running count ticks immediately.
module divisor_tick #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 ENABLE,
  input  logic [DIV_WIDTH-1:0] DIV,
  output logic                 TICK
);

  localparam logic [DIV_WIDTH-1:0] UNO = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] cuenta_r;
  logic                 tick_s;

  assign tick_s = ENABLE & (cuenta_r >= DIV);
  assign TICK   = tick_s;

  // count register, held while disabled
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cuenta_r <= '0;
    end else if (tick_s) begin
      cuenta_r <= '0;
    end else if (ENABLE) begin
      cuenta_r <= cuenta_r + UNO;
    end else begin
      cuenta_r <= cuenta_r;
    end
  end

endmodule

// File: rtl/luces_secuenciador.sv
// Parametrised LED pattern sequencer for the LEDG bank: rotate left/right,
// ping-pong and fill/drain, stepped by a programmable prescaler.
module luces_secuenciador
  import luces_pkg::*;
#(
  parameter int N_LEDS    = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 ENABLE,
  input  logic [1:0]           MODE,
  input  logic [DIV_WIDTH-1:0] DIV,
  output logic [N_LEDS-1:0]    LEDG,
  output logic                 STEP,
  output logic                 WRAP
);

  localparam logic [N_LEDS-1:0] LED_B0   = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] LED_MSB  = {1'b1, {(N_LEDS-1){1'b0}}};
  localparam logic [N_LEDS-1:0] LED_UNOS = {N_LEDS{1'b1}};

  estado_t             estado_r, estado_s;
  logic [N_LEDS-1:0]   led_r, led_s;
  logic [1:0]          modo_r, modo_s;
  logic                step_r, step_s;
  logic                wrap_r, wrap_s;
  logic                tick_s;
  logic                div_en_s;
  logic [N_LEDS-1:0]   rotl_s, rotr_s, shl_s, shr_s, fill_s;

  function automatic logic [N_LEDS-1:0] patron_inicial(input logic [1:0] modo);
    if (modo == MODO_ROT_R) begin
      return LED_MSB;
    end else begin
      return LED_B0;
    end
  endfunction

  // The prescaler only runs once a pattern is active, so the first advance
  // lands DIV+1 cycles after the initial pattern appears.
  assign div_en_s = ENABLE & (estado_r != ST_IDLE);

  divisor_tick #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .ENABLE (div_en_s),
    .DIV    (DIV),
    .TICK   (tick_s)
  );

  assign rotl_s = {led_r[N_LEDS-2:0], led_r[N_LEDS-1]};
  assign rotr_s = {led_r[0], led_r[N_LEDS-1:1]};
  assign shl_s  = {led_r[N_LEDS-2:0], 1'b0};
  assign shr_s  = {1'b0, led_r[N_LEDS-1:1]};
  assign fill_s = {led_r[N_LEDS-2:0], 1'b1};

  // next state, next pattern and STEP/WRAP pulses
  always_comb begin
    estado_s = estado_r;
    led_s    = led_r;
    modo_s   = modo_r;
    step_s   = 1'b0;
    wrap_s   = 1'b0;
    if (estado_r == ST_IDLE) begin
      if (ENABLE) begin
        led_s    = patron_inicial(MODE);
        estado_s = primer_estado(MODE);
        modo_s   = MODE;
        step_s   = 1'b1;
      end else begin
        estado_s = ST_IDLE;
      end
    end else if (tick_s) begin
      step_s = 1'b1;
      if (MODE != modo_r) begin
        led_s    = patron_inicial(MODE);
        estado_s = primer_estado(MODE);
        modo_s   = MODE;
      end else begin
        case (estado_r)
          ST_ROT_L: begin
            led_s  = rotl_s;
            wrap_s = (rotl_s == LED_B0);
          end
          ST_ROT_R: begin
            led_s  = rotr_s;
            wrap_s = (rotr_s == LED_MSB);
          end
          ST_PP_UP: begin
            led_s = shl_s;
            if (shl_s[N_LEDS-1]) begin
              estado_s = ST_PP_DOWN;
            end else begin
              estado_s = ST_PP_UP;
            end
          end
          ST_PP_DOWN: begin
            led_s = shr_s;
            if (shr_s[0]) begin
              estado_s = ST_PP_UP;
              wrap_s   = 1'b1;
            end else begin
              estado_s = ST_PP_DOWN;
            end
          end
          ST_FILL: begin
            led_s = fill_s;
            if (fill_s == LED_UNOS) begin
              estado_s = ST_DRAIN;
            end else begin
              estado_s = ST_FILL;
            end
          end
          // the empty bank is shown for one tick before refilling
          ST_DRAIN: begin
            if (led_r == '0) begin
              led_s    = LED_B0;
              estado_s = ST_FILL;
              wrap_s   = 1'b1;
            end else begin
              led_s    = shl_s;
              estado_s = ST_DRAIN;
            end
          end
          default: begin
            estado_s = ST_IDLE;
            led_s    = '0;
            modo_s   = 2'd0;
            step_s   = 1'b0;
          end
        endcase
      end
    end else begin
      estado_s = estado_r;
    end
  end

  // state and output registers
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      estado_r <= ST_IDLE;
      led_r    <= '0;
      modo_r   <= 2'd0;
      step_r   <= 1'b0;
      wrap_r   <= 1'b0;
    end else begin
      estado_r <= estado_s;
      led_r    <= led_s;
      modo_r   <= modo_s;
      step_r   <= step_s;
      wrap_r   <= wrap_s;
    end
  end

  assign LEDG = led_r;
  assign STEP = step_r;
  assign WRAP = wrap_r;

endmodule
